// File: rtl/id_ex_stage_if.sv
// Signal bundle between the decode stage, the ID/EX pipeline register and the EX-stage forwarding muxes.
// The stage itself uses the slave modport; the decode/hazard environment uses master.
interface id_ex_stage_if #(
   parameter int CTRL_W = 8,
   parameter int DATA_W = 32
);
   logic              id_valid;
   logic [4:0]        id_rs;
   logic [4:0]        id_rt;
   logic [4:0]        id_rd;
   logic              id_reg_dst;
   logic              id_reg_write;
   logic              id_mem_read;
   logic [CTRL_W-1:0] id_ctrl;
   logic [DATA_W-1:0] id_rd1;
   logic [DATA_W-1:0] id_rd2;
   logic [DATA_W-1:0] id_imm;
   logic              flush;
   logic              exm_reg_write;
   logic [4:0]        exm_dest;
   logic              mwb_reg_write;
   logic [4:0]        mwb_dest;
   logic [DATA_W-1:0] mwb_data;

   logic              stall;
   logic              ex_valid;
   logic              ex_reg_write;
   logic              ex_mem_read;
   logic [4:0]        ex_rs;
   logic [4:0]        ex_rt;
   logic [4:0]        ex_dest;
   logic [CTRL_W-1:0] ex_ctrl;
   logic [DATA_W-1:0] ex_rd1;
   logic [DATA_W-1:0] ex_rd2;
   logic [DATA_W-1:0] ex_imm;
   logic [1:0]        fwd_a;
   logic [1:0]        fwd_b;

   modport master (
      output id_valid, id_rs, id_rt, id_rd, id_reg_dst, id_reg_write, id_mem_read,
             id_ctrl, id_rd1, id_rd2, id_imm, flush,
             exm_reg_write, exm_dest, mwb_reg_write, mwb_dest, mwb_data,
      input  stall, ex_valid, ex_reg_write, ex_mem_read, ex_rs, ex_rt, ex_dest,
             ex_ctrl, ex_rd1, ex_rd2, ex_imm, fwd_a, fwd_b
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_rd, id_reg_dst, id_reg_write, id_mem_read,
             id_ctrl, id_rd1, id_rd2, id_imm, flush,
             exm_reg_write, exm_dest, mwb_reg_write, mwb_dest, mwb_data,
      output stall, ex_valid, ex_reg_write, ex_mem_read, ex_rs, ex_rt, ex_dest,
             ex_ctrl, ex_rd1, ex_rd2, ex_imm, fwd_a, fwd_b
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, branch flush and EX operand-forwarding selects.
// Optional macro IDEX_WB_BYPASS_EN: capture the same-edge WB write data instead of the stale regfile read.
module id_ex_stage #(
   parameter int CTRL_W = 8,
   parameter int DATA_W = 32
) (
   input logic         clk,
   input logic         reset,
   id_ex_stage_if.slave bus
);

   logic              ex_valid;
   logic              ex_reg_write;
   logic              ex_mem_read;
   logic [4:0]        ex_rs;
   logic [4:0]        ex_rt;
   logic [4:0]        ex_dest;
   logic [CTRL_W-1:0] ex_ctrl;
   logic [DATA_W-1:0] ex_rd1;
   logic [DATA_W-1:0] ex_rd2;
   logic [DATA_W-1:0] ex_imm;

   logic              stall;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [1:0]        fwd_a;
   logic [1:0]        fwd_b;

   // A load in EX whose destination feeds the ID instruction needs one bubble; r0 never hazards.
   always_comb begin
      stall = !bus.flush && bus.id_valid && ex_valid && ex_mem_read && (ex_dest != 5'd0)
              && ((ex_dest == bus.id_rs) || (ex_dest == bus.id_rt));
   end

`ifdef IDEX_WB_BYPASS_EN
   always_comb begin
      op_a = bus.id_rd1;
      op_b = bus.id_rd2;
      if (bus.mwb_reg_write && (bus.mwb_dest != 5'd0) && (bus.mwb_dest == bus.id_rs)) begin
         op_a = bus.mwb_data;
      end
      if (bus.mwb_reg_write && (bus.mwb_dest != 5'd0) && (bus.mwb_dest == bus.id_rt)) begin
         op_b = bus.mwb_data;
      end
   end
`else
   logic unused_wb_data;
   assign unused_wb_data = ^bus.mwb_data;

   always_comb begin
      op_a = bus.id_rd1;
      op_b = bus.id_rd2;
   end
`endif

   // Reset, flush and stall all insert the same all-zero bubble.
   always_ff @(posedge clk) begin
      if (reset || bus.flush || stall) begin
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_rs        <= '0;
         ex_rt        <= '0;
         ex_dest      <= '0;
         ex_ctrl      <= '0;
         ex_rd1       <= '0;
         ex_rd2       <= '0;
         ex_imm       <= '0;
      end else begin
         ex_valid     <= bus.id_valid;
         ex_reg_write <= bus.id_reg_write;
         ex_mem_read  <= bus.id_mem_read;
         ex_rs        <= bus.id_rs;
         ex_rt        <= bus.id_rt;
         ex_dest      <= bus.id_reg_dst ? bus.id_rd : bus.id_rt;
         ex_ctrl      <= bus.id_ctrl;
         ex_rd1       <= op_a;
         ex_rd2       <= op_b;
         ex_imm       <= bus.id_imm;
      end
   end

   // EX/MEM is the younger producer, so it wins over MEM/WB.
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (ex_valid) begin
         if (bus.exm_reg_write && (bus.exm_dest != 5'd0) && (bus.exm_dest == ex_rs)) begin
            fwd_a = 2'b10;
         end else if (bus.mwb_reg_write && (bus.mwb_dest != 5'd0) && (bus.mwb_dest == ex_rs)) begin
            fwd_a = 2'b01;
         end
         if (bus.exm_reg_write && (bus.exm_dest != 5'd0) && (bus.exm_dest == ex_rt)) begin
            fwd_b = 2'b10;
         end else if (bus.mwb_reg_write && (bus.mwb_dest != 5'd0) && (bus.mwb_dest == ex_rt)) begin
            fwd_b = 2'b01;
         end
      end
   end

   assign bus.stall        = stall;
   assign bus.ex_valid     = ex_valid;
   assign bus.ex_reg_write = ex_reg_write;
   assign bus.ex_mem_read  = ex_mem_read;
   assign bus.ex_rs        = ex_rs;
   assign bus.ex_rt        = ex_rt;
   assign bus.ex_dest      = ex_dest;
   assign bus.ex_ctrl      = ex_ctrl;
   assign bus.ex_rd1       = ex_rd1;
   assign bus.ex_rd2       = ex_rd2;
   assign bus.ex_imm       = ex_imm;
   assign bus.fwd_a        = fwd_a;
   assign bus.fwd_b        = fwd_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage: table of per-cycle inputs with hand-computed outputs,
// plus hand-written load-use and mid-run reset sequences.
module tb_id_ex_stage;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   id_ex_stage_if #(.CTRL_W(8), .DATA_W(32)) bus ();

   id_ex_stage #(.CTRL_W(8), .DATA_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef IDEX_WB_BYPASS_EN
   localparam logic [31:0] BYP_RD1 = 32'h0000_DEAD;
`else
   localparam logic [31:0] BYP_RD1 = 32'h0000_BEEF;
`endif

   typedef struct {
      logic        rst;
      logic        vld;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic        rdst;
      logic        rw;
      logic        mr;
      logic [7:0]  ctrl;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic        fl;
      logic        xw;
      logic [4:0]  xd;
      logic        ww;
      logic [4:0]  wd;
      logic [31:0] wdata;
      logic        chk;
      logic        e_stall;
      logic [1:0]  e_fa;
      logic [1:0]  e_fb;
      logic        e_vld;
      logic        e_rw;
      logic        e_mr;
      logic [4:0]  e_dest;
      logic [7:0]  e_ctrl;
      logic [31:0] e_rd1;
      logic [31:0] e_rd2;
      logic [31:0] e_imm;
   } vec_t;

   vec_t vecs[17];

   task automatic applyStimulus(input vec_t v);
      reset             = v.rst;
      bus.id_valid      = v.vld;
      bus.id_rs         = v.rs;
      bus.id_rt         = v.rt;
      bus.id_rd         = v.rd;
      bus.id_reg_dst    = v.rdst;
      bus.id_reg_write  = v.rw;
      bus.id_mem_read   = v.mr;
      bus.id_ctrl       = v.ctrl;
      bus.id_rd1        = v.rd1;
      bus.id_rd2        = v.rd2;
      bus.id_imm        = v.imm;
      bus.flush         = v.fl;
      bus.exm_reg_write = v.xw;
      bus.exm_dest      = v.xd;
      bus.mwb_reg_write = v.ww;
      bus.mwb_dest      = v.wd;
      bus.mwb_data      = v.wdata;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      vec_t v;
      int   stall_cycles;
      checks = 0;
      errors = 0;

      // rst vld rs rt rd rdst rw mr ctrl rd1 rd2 imm fl xw xd ww wd wdata | chk stall fa fb | vld rw mr dest ctrl rd1 rd2 imm
      vecs[0]  = '{1,0, 0, 0, 0,0,0,0,8'h00,32'h0,32'h0,32'h0,0, 0,0, 0,0,32'h0,    0,0,0,0, 0,0,0, 0,8'h00,32'h0,32'h0,32'h0};
      vecs[1]  = '{1,1, 3, 4, 5,1,1,0,8'h5A,32'h11,32'h22,32'h33,0, 0,0, 0,0,32'h0, 1,0,0,0, 0,0,0, 0,8'h00,32'h0,32'h0,32'h0};
      vecs[2]  = '{0,1, 3, 4, 5,1,1,0,8'h5A,32'h11,32'h22,32'h33,0, 0,0, 0,0,32'h0, 1,0,0,0, 1,1,0, 5,8'h5A,32'h11,32'h22,32'h33};
      vecs[3]  = '{0,1, 2, 8, 0,0,1,1,8'h81,32'h100,32'h200,32'h4,0, 1,3, 1,4,32'h0, 1,0,2,1, 1,1,1, 8,8'h81,32'h100,32'h200,32'h4};
      vecs[4]  = '{0,1, 8, 9,10,1,1,0,8'h12,32'h300,32'h301,32'h0,0, 0,0, 0,0,32'h0, 1,1,0,0, 0,0,0, 0,8'h00,32'h0,32'h0,32'h0};
      vecs[5]  = '{0,1, 8, 9,10,1,1,0,8'h12,32'h300,32'h301,32'h0,0, 0,0, 0,0,32'h0, 1,0,0,0, 1,1,0,10,8'h12,32'h300,32'h301,32'h0};
      vecs[6]  = '{0,1, 7, 0, 0,0,0,0,8'h03,32'h700,32'h0,32'h0,0,  1,8, 1,8,32'h0, 1,0,2,0, 1,0,0, 0,8'h03,32'h700,32'h0,32'h0};
      vecs[7]  = '{0,1, 7, 0, 0,0,0,0,8'h03,32'h700,32'h0,32'h0,0,  1,7, 1,6,32'h0, 1,0,2,0, 1,0,0, 0,8'h03,32'h700,32'h0,32'h0};
      vecs[8]  = '{0,1, 0, 0, 0,0,0,0,8'h06,32'h55,32'h0,32'h0,0,   0,7, 1,7,32'h0, 1,0,1,0, 1,0,0, 0,8'h06,32'h55,32'h0,32'h0};
      vecs[9]  = '{0,1, 1, 0, 0,0,1,1,8'h81,32'h1,32'h0,32'h0,0,    1,0, 1,0,32'h0, 1,0,0,0, 1,1,1, 0,8'h81,32'h1,32'h0,32'h0};
      vecs[10] = '{0,1, 0, 0, 3,1,1,0,8'h22,32'h2,32'h0,32'h0,0,    0,0, 0,0,32'h0, 1,0,0,0, 1,1,0, 3,8'h22,32'h2,32'h0,32'h0};
      vecs[11] = '{0,1, 1,12, 0,0,1,1,8'h81,32'h3,32'h0,32'h0,0,    0,0, 0,0,32'h0, 1,0,0,0, 1,1,1,12,8'h81,32'h3,32'h0,32'h0};
      vecs[12] = '{0,1,12, 1, 4,1,1,0,8'h44,32'h4,32'h0,32'h0,1,    0,0, 0,0,32'h0, 1,0,0,0, 0,0,0, 0,8'h00,32'h0,32'h0,32'h0};
      vecs[13] = '{0,1, 9, 2, 6,1,1,0,8'h09,32'hBEEF,32'h77,32'h0,0,0,0, 1,9,32'hDEAD, 1,0,0,0, 1,1,0, 6,8'h09,BYP_RD1,32'h77,32'h0};
      vecs[14] = '{0,1, 1,13, 0,0,1,1,8'h81,32'h5,32'h0,32'h0,0,    1,2, 1,9,32'hDEAD, 1,0,1,2, 1,1,1,13,8'h81,32'h5,32'h0,32'h0};
      vecs[15] = '{0,1, 0,13, 7,1,1,0,8'h33,32'h6,32'h0,32'h0,0,    0,0, 1,0,32'hFFFF, 1,1,0,0, 0,0,0, 0,8'h00,32'h0,32'h0,32'h0};
      vecs[16] = '{0,1, 0,13, 7,1,1,0,8'h33,32'h6,32'h0,32'h0,0,    0,0, 1,0,32'hFFFF, 1,0,0,0, 1,1,0, 7,8'h33,32'h6,32'h0,32'h0};

      // Inputs change just after a rising edge; combinational outputs are sampled mid-cycle, registers #1 after the edge.
      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i]);
         #2;
         if (vecs[i].chk) begin
            checkOutput($sformatf("v%0d stall", i), {31'd0, bus.stall}, {31'd0, vecs[i].e_stall});
            checkOutput($sformatf("v%0d fwd_a", i), {30'd0, bus.fwd_a}, {30'd0, vecs[i].e_fa});
            checkOutput($sformatf("v%0d fwd_b", i), {30'd0, bus.fwd_b}, {30'd0, vecs[i].e_fb});
         end
         @(posedge clk);
         #1;
         checkOutput($sformatf("v%0d ex_valid", i), {31'd0, bus.ex_valid}, {31'd0, vecs[i].e_vld});
         checkOutput($sformatf("v%0d ex_reg_write", i), {31'd0, bus.ex_reg_write}, {31'd0, vecs[i].e_rw});
         checkOutput($sformatf("v%0d ex_mem_read", i), {31'd0, bus.ex_mem_read}, {31'd0, vecs[i].e_mr});
         checkOutput($sformatf("v%0d ex_dest", i), {27'd0, bus.ex_dest}, {27'd0, vecs[i].e_dest});
         checkOutput($sformatf("v%0d ex_ctrl", i), {24'd0, bus.ex_ctrl}, {24'd0, vecs[i].e_ctrl});
         checkOutput($sformatf("v%0d ex_rd1", i), bus.ex_rd1, vecs[i].e_rd1);
         checkOutput($sformatf("v%0d ex_rd2", i), bus.ex_rd2, vecs[i].e_rd2);
         checkOutput($sformatf("v%0d ex_imm", i), bus.ex_imm, vecs[i].e_imm);
      end

      // Load to r20 followed by a reader held in ID: exactly one stall cycle, then the reader enters EX.
      v = vecs[0];
      v.rst = 0; v.vld = 1; v.rs = 5'd1; v.rt = 5'd20; v.rdst = 0; v.rw = 1; v.mr = 1; v.ctrl = 8'h81;
      applyStimulus(v);
      @(posedge clk);
      #1;
      v.rs = 5'd20; v.rt = 5'd2; v.rd = 5'd21; v.rdst = 1; v.mr = 0; v.ctrl = 8'h5C; v.rd1 = 32'hABC;
      applyStimulus(v);
      stall_cycles = 0;
      for (int c = 0; c < 3; c++) begin
         #2;
         if (bus.stall === 1'b1) stall_cycles++;
         @(posedge clk);
         #1;
      end
      checkOutput("seq stall_cycles", stall_cycles, 32'd1);
      checkOutput("seq ex_dest", {27'd0, bus.ex_dest}, 32'd21);
      checkOutput("seq ex_rd1", bus.ex_rd1, 32'hABC);

      // Reset asserted mid-run with a valid instruction in ID still yields a bubble.
      v.rst = 1;
      applyStimulus(v);
      @(posedge clk);
      #1;
      checkOutput("rst ex_valid", {31'd0, bus.ex_valid}, 32'd0);
      checkOutput("rst ex_ctrl", {24'd0, bus.ex_ctrl}, 32'd0);
      v.rst = 0;
      applyStimulus(v);
      @(posedge clk);
      #1;
      checkOutput("rel ex_valid", {31'd0, bus.ex_valid}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
